pulse_stretch: RTL and testbench

Converts single-cycle pulses, such as those produced by the team's edge/pulse generators, back into multi-cycle level waveforms of programmable length. It is the receiving end of the pulse path: a pulse launched in one part of the design becomes a level wide enough for slower consumers or for re-edge-detection downstream. Two modes are supported:
- **Queued:** pulses arriving while the output is high are counted and replayed.
- **Retrigger:** pulses arriving while the output is high extend it.

---
 rtl/pulse_stretch_if.sv | 28 ++
 rtl/pulse_stretch.sv | 142 ++++++++++++++
 tb/tb_pulse_stretch.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretch_if.sv
// Signal bundle for the pulse stretcher: the pulse/configuration inputs
// driven by the producer side and the stretched level plus status seen
// by the consumer side.
interface pulse_stretch_if #(
    parameter int LEN_W  = 8,
    parameter int PEND_W = 4
);
    logic              pulse_in;
    logic [LEN_W-1:0]  len;
    logic              retrig;
    logic              clr_ovf;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    // Producer of pulses / observer of the stretched level.
    modport master (
        output pulse_in, len, retrig, clr_ovf,
        input  level_out, busy, pending, overflow
    );

    // The stretcher itself.
    modport slave (
        input  pulse_in, len, retrig, clr_ovf,
        output level_out, busy, pending, overflow
    );
endinterface

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns single-cycle pulses into level waveforms of
// max(len,1) cycles. In queued mode pulses arriving while the output is
// high are counted and replayed, separated by one forced low cycle so a
// downstream edge detector sees every one. In retrigger mode such pulses
// extend the current level instead. All outputs come straight from flops.
module pulse_stretch #(
    parameter int LEN_W  = 8,
    parameter int PEND_W = 4
) (
    input  logic           clk,
    input  logic           rstn,
    pulse_stretch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              level_q, level_d;
    logic              busy_q, busy_d;
    logic              ovf_set;
    logic [LEN_W-1:0]  load_val;

    // A requested length of zero still produces a one-cycle level.
    assign load_val = (bus.len == '0) ? CNT_ONE : bus.len;

    // Next-state, down-counter and pending-queue update.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no
        // path through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.pulse_in) begin
                    cnt_d   = load_val;
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                // A retrigger reload takes priority over expiry.
                if (bus.retrig && bus.pulse_in) begin
                    cnt_d = load_val;
                end else if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end

                // Queued mode remembers the pulse, or drops it when full.
                if (!bus.retrig && bus.pulse_in) begin
                    if (pend_q == PEND_MAX) begin
                        ovf_set = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_ONE;
                    end
                end
            end

            ST_GAP: begin
                if (bus.pulse_in || (pend_q != '0)) begin
                    cnt_d   = load_val;
                    state_d = ST_HIGH;
                    // A fresh pulse is served directly; otherwise consume one
                    // queued pulse. With both, queue-in and queue-out cancel.
                    if (!bus.pulse_in) begin
                        pend_d = pend_q - PEND_ONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered
    // without adding a cycle of latency; sticky overflow with set priority.
    always_comb begin
        level_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State, counter and queue registers.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the values from before the edge.
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pend_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch. The reference model tracks the
// edge index at which the current level must fall and an integer queue
// count, and derives IDLE/HIGH/GAP from the previous expected outputs.
module tb_pulse_stretch;

    localparam int LEN_W  = 8;
    localparam int PEND_W = 4;
    localparam int PMAX   = (1 << PEND_W) - 1;
    localparam int VW     = PEND_W + 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    pulse_stretch_if #(.LEN_W(LEN_W), .PEND_W(PEND_W)) bus ();

    pulse_stretch #(.LEN_W(LEN_W), .PEND_W(PEND_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int t      = 0;   // edge index
    int end_t  = 0;   // first edge at which the level is low again
    int m_pend = 0;
    bit m_level, m_busy, m_ovf;

    task automatic m_reset();
        m_level = 1'b0;
        m_busy  = 1'b0;
        m_ovf   = 1'b0;
        m_pend  = 0;
        end_t   = t;
    endtask

    task automatic m_update(input bit p, input int l, input bit rt, input bit c);
        int L;
        bit was_high, was_gap, ovf_set;
        L        = (l == 0) ? 1 : l;
        was_high = m_level;
        was_gap  = m_busy && !m_level;
        ovf_set  = 1'b0;
        if (was_high) begin
            if (rt && p) end_t = t + L;
            else if (p) begin
                if (m_pend == PMAX) ovf_set = 1'b1;
                else m_pend++;
            end
            m_level = (t < end_t);
            m_busy  = 1'b1;
        end else if (was_gap) begin
            if (p || m_pend > 0) begin
                end_t   = t + L;
                m_level = 1'b1;
                m_busy  = 1'b1;
                if (!p) m_pend--;
            end else begin
                m_level = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (p) begin
            end_t   = t + L;
            m_level = 1'b1;
            m_busy  = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (c)  m_ovf = 1'b0;
        t++;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {m_level, m_busy, PEND_W'(m_pend), m_ovf};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.level_out, bus.busy, bus.pending, bus.overflow};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input bit p, input int l, input bit c);
        bus.pulse_in = p;
        bus.len      = LEN_W'(l);
        bus.clr_ovf  = c;
        @(posedge clk);
        m_update(p, l, bus.retrig, c);
        #1;
        bus.pulse_in = 1'b0;
        bus.clr_ovf  = 1'b0;
    endtask

    task automatic test_reset();
        bus.pulse_in = 1'b0;
        bus.len      = '0;
        bus.retrig   = 1'b0;
        bus.clr_ovf  = 1'b0;
        m_reset();
        #12;
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold got %b expected %b", obs_vec(), {VW{1'b0}});
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        int highs = 0;
        int busys = 0;
        bus.retrig = 1'b0;
        for (int i = 0; i < 10; i++) begin
            // len moves away from 5 mid-pulse; only the load value counts
            step(i == 0, (i == 0) ? 5 : 9, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
            highs += int'(bus.level_out);
            busys += int'(bus.busy);
        end
        n_checks++;
        if (highs !== 5) begin
            n_fail++;
            $display("FAIL single_high_cycles got %0d expected 5", highs);
        end
        n_checks++;
        if (busys !== 6) begin
            n_fail++;
            $display("FAIL single_busy_cycles got %0d expected 6", busys);
        end
    endtask

    task automatic test_len0();
        int highs = 0;
        for (int i = 0; i < 5; i++) begin
            step(i == 0, 0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL len0_model t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
            highs += int'(bus.level_out);
        end
        n_checks++;
        if (highs !== 1) begin
            n_fail++;
            $display("FAIL len0_high_cycles got %0d expected 1", highs);
        end
    endtask

    task automatic test_queued();
        logic [15:0] lvl_seq;
        int          pend_max = 0;
        lvl_seq = '0;
        for (int i = 0; i < 18; i++) begin
            step((i == 0) || (i == 2) || (i == 3), 4, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL queued_model t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
            if (i < 16) lvl_seq[i] = bus.level_out;
            if (int'(bus.pending) > pend_max) pend_max = int'(bus.pending);
        end
        // 4 high, 1 low, 4 high, 1 low, 4 high, then low (bit 0 first)
        n_checks++;
        if (lvl_seq !== 16'h3DEF) begin
            n_fail++;
            $display("FAIL queued_waveform got %h expected 3def", lvl_seq);
        end
        n_checks++;
        if (pend_max !== 2) begin
            n_fail++;
            $display("FAIL queued_pending_peak got %0d expected 2", pend_max);
        end
        n_checks++;
        if (bus.pending !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL queued_end got pending=%0d busy=%b expected 0 0", bus.pending, bus.busy);
        end
    endtask

    task automatic test_overflow();
        int  rises  = 0;
        int  cycles = 0;
        logic prev;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 20, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_fill t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bus.pending !== 4'd15 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_saturate got pending=%0d ovf=%b expected 15 1", bus.pending, bus.overflow);
        end
        step(1'b1, 20, 1'b1);  // clear together with another drop
        n_checks++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins got %b expected 1", bus.overflow);
        end
        step(1'b0, 20, 1'b1);
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b expected 0", bus.overflow);
        end
        prev = bus.level_out;
        while (m_busy && cycles < 600) begin
            step(1'b0, 3, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_drain t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
            if (bus.level_out && !prev) rises++;
            prev = bus.level_out;
            cycles++;
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain_timeout got busy=%b expected 0", bus.busy);
        end
        n_checks++;
        if (rises !== 15) begin
            n_fail++;
            $display("FAIL ovf_replays got %0d expected 15", rises);
        end
    endtask

    task automatic test_retrigger();
        int highs    = 0;
        int rises    = 0;
        int pend_max = 0;
        logic prev   = 1'b0;
        bus.retrig = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step((i == 0) || (i == 4), 6, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL retrig_model t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
            highs += int'(bus.level_out);
            if (bus.level_out && !prev) rises++;
            prev = bus.level_out;
            if (int'(bus.pending) > pend_max) pend_max = int'(bus.pending);
        end
        n_checks++;
        if (highs !== 10 || rises !== 1) begin
            n_fail++;
            $display("FAIL retrig_extend got highs=%0d rises=%0d expected 10 1", highs, rises);
        end
        n_checks++;
        if (pend_max !== 0) begin
            n_fail++;
            $display("FAIL retrig_pending got %0d expected 0", pend_max);
        end
        bus.retrig = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.pending !== 4'd2) begin
            n_fail++;
            $display("FAIL arst_setup got %b expected %b", obs_vec(), exp_vec());
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate got %b expected %b", obs_vec(), {VW{1'b0}});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL arst_held got %b expected %b", obs_vec(), {VW{1'b0}});
        end
        #3;
        rstn = 1'b1;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            step(i == 3, 2, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL arst_after t=%0d got %b expected %b", t, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int thr = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) thr = int'($urandom_range(5, 90));
            if (!m_busy && $urandom_range(0, 19) == 0) bus.retrig = 1'($urandom_range(0, 1));
            step(int'($urandom_range(0, 99)) < thr, int'($urandom_range(0, 6)),
                 $urandom_range(0, 15) == 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random t=%0d retrig=%b got %b expected %b",
                         t, bus.retrig, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_len0();
        test_queued();
        test_overflow();
        test_retrigger();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
